// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier controller.
// One WIDTH-bit adder (carry-out kept, no carry-in) is reused for WIDTH
// iterations. ACC:Q form the running double-width partial product that
// shifts right one bit per iteration, so the multiplier bits of Q are
// consumed LSB first while the product bits fill in from the top.
// WIDTH must be at least 2.
module shift_add_mul_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH:0]       sum_s;

    // Shared adder: ACC plus the multiplicand gated by the current multiplier LSB.
    always_comb begin
        addend_s = {WIDTH{1'b0}};
        if (q_q[0]) begin
            addend_s = m_q;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s = {1'b0, acc_q} + {1'b0, addend_s};
    end

    // Next-state and datapath update for the sequencing FSM.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = {WIDTH{1'b0}};
                    count_d = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Carry-out lands in ACC MSB; the sum LSB moves into Q's top.
                acc_d   = sum_s[WIDTH:1];
                q_d     = {sum_s[0], q_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    product_d = {sum_s[WIDTH:1], sum_s[0], q_q[WIDTH-1:1]};
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            count_q   <= {CW{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Status flags decoded purely from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            ST_RUN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: doc/shift_add_mul_ctrl.md
Name: shift_add_mul_ctrl

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier controller.
- Time-shares one WIDTH-bit ripple adder (the team's 4-bit carry-out adder when WIDTH=4) across WIDTH shift-and-add iterations.
- Sits between a requester issuing single multiply commands and the shared adder datapath; it owns operand/partial-product registers and the sequencing FSM.

Parameters:
- WIDTH, 4, operand width in bits. Adder result is WIDTH+1 bits (carry-out in MSB, no carry-in). Product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high while a multiply is in progress (RUN and DONE states).
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  registered result; holds until next accepted start.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge), regardless of state:
  - state=IDLE; busy=0, done=0, product=0.
  - Internal M, Q, ACC and count cleared to 0.
  - Reset mid-operation aborts the operation: no done pulse, product=0.
- Internal registers:
  - M[WIDTH-1:0] = multiplicand.
  - Q[WIDTH-1:0] = multiplier, shifting right.
  - ACC[WIDTH-1:0] = upper partial product.
  - count sized $clog2(WIDTH)+1.
- Adder input: adder operands are ACC and (Q[0] ? M : 0). sum[WIDTH:0] is the adder output.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E0: M<=a, Q<=b, ACC<=0, count<=0, go RUN.
- RUN, one iteration per edge:
  - ACC <= sum[WIDTH:1].
  - Q <= {sum[0], Q[WIDTH-1:1]}.
  - count <= count+1.
  - On the edge where count==WIDTH-1 (iteration WIDTH, edge E_WIDTH): product <= {sum[WIDTH:1], sum[0], Q[WIDTH-1:1]}, go DONE.
- DONE:
  - done=1 for exactly this cycle, busy=1.
  - Next edge: go IDLE.
- Latency: start accepted at E0 -> done high in the cycle following edge E_WIDTH, i.e. WIDTH+1 cycles after acceptance.
  - Throughput: one multiply per WIDTH+2 cycles.
  - done and busy are both combinational decodes of the registered state; no glitch paths from inputs.
- start while busy (RUN or DONE): ignored, no queueing. a/b changes while busy have no effect.
- start held high continuously: re-accepted on the first IDLE edge after DONE, giving back-to-back operations with one idle cycle between them.
- Arithmetic:
  - Unsigned only; no overflow possible.
  - Max result (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - The adder carry-out is never dropped; it shifts into ACC MSB.
- Zero operands: still take the full WIDTH iterations; no early termination.
- product output changes only at the completing RUN edge or at reset; stable in IDLE.

Test Plan:
- Reset, then a=15, b=15, start 1 cycle -> busy high next cycle; done pulses exactly 5 cycles after acceptance; product=0xE1 (225); busy low the cycle after done.
- a=10, b=11 -> product=0x6E (110). Then a=0, b=9 -> product=0x00, done still arrives after 5 cycles. Then a=1, b=13 -> product=0x0D.
- Accept a=3, b=5; two cycles later pulse start with a=7, b=7 -> second request ignored; product=0x0F; only one done pulse.
- Accept a=12, b=12; assert rst on the 3rd RUN cycle -> next cycle busy=0, done=0, product=0; no done pulse follows. A new start with a=2, b=3 -> product=0x06.
- Hold start=1 with a=9, b=6 across two operations -> done pulses exactly 6 cycles apart, product=0x36 both times, busy low for exactly one cycle between operations.
- Exhaustive sweep of all 256 (a,b) pairs for WIDTH=4 against a reference a*b; also check done is never high in IDLE or RUN.
